// File: rtl/siphash_pkg.sv
// Shared SipHash definitions: word geometry and the message padder's state encoding.
package siphash_pkg;

  localparam int WORD_W         = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_IDX_W     = 3;
  localparam int LEN_W          = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_COLLECT,
    ST_COMP_ISSUE,
    ST_COMP_WAIT,
    ST_PAD,
    ST_FIN_C_ISSUE,
    ST_FIN_C_WAIT,
    ST_FIN_ISSUE,
    ST_FIN_WAIT
  } state_e;

endpackage

// File: rtl/siphash_msg_padder.sv
// Packs a byte stream into little-endian 64-bit words, appends the SipHash length
// byte and sequences initialize/compress/finalize commands to a SipHash core.
module siphash_msg_padder
  import siphash_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              end_msg,
  input  logic              core_ready,
  output logic              core_initalize,
  output logic              core_compress,
  output logic              core_finalize,
  output logic [WORD_W-1:0] core_mi,
  output logic              busy,
  output logic              done,
  output state_e            state_dbg
);

  // Handshakes: a byte moves when byte_valid && byte_ready on a rising edge; a core
  // command is raised only in a cycle where core_ready=1 and lasts exactly that cycle.

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                state, state_nxt;
  logic [WORD_W-1:0]     word_reg;
  logic [BYTE_IDX_W-1:0] byte_ctr;
  logic [LEN_W-1:0]      len_ctr;
  logic                  last_flag;

  logic ready_c, init_c, comp_c, fin_c, done_c, mi_sel;
  logic accept;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    init_c    = 1'b0;
    comp_c    = 1'b0;
    fin_c     = 1'b0;
    done_c    = 1'b0;
    mi_sel    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (core_ready) begin
          init_c    = 1'b1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        ready_c = 1'b1;
        // A completed word takes priority; last_flag carries the end request along.
        if (byte_valid && (byte_ctr == LAST_IDX)) state_nxt = ST_COMP_ISSUE;
        else if (end_msg)                         state_nxt = ST_PAD;
      end
      ST_COMP_ISSUE: begin
        mi_sel = 1'b1;
        if (core_ready) begin
          comp_c    = 1'b1;
          state_nxt = ST_COMP_WAIT;
        end
      end
      ST_COMP_WAIT: begin
        mi_sel = 1'b1;
        if (core_ready) state_nxt = last_flag ? ST_PAD : ST_COLLECT;
      end
      ST_PAD: begin
        state_nxt = ST_FIN_C_ISSUE;
      end
      ST_FIN_C_ISSUE: begin
        mi_sel = 1'b1;
        if (core_ready) begin
          comp_c    = 1'b1;
          state_nxt = ST_FIN_C_WAIT;
        end
      end
      ST_FIN_C_WAIT: begin
        mi_sel = 1'b1;
        if (core_ready) state_nxt = ST_FIN_ISSUE;
      end
      ST_FIN_ISSUE: begin
        if (core_ready) begin
          fin_c     = 1'b1;
          state_nxt = ST_FIN_WAIT;
        end
      end
      ST_FIN_WAIT: begin
        if (core_ready) begin
          done_c    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = ready_c & byte_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_reg  <= '0;
      byte_ctr  <= '0;
      len_ctr   <= '0;
      last_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            word_reg  <= '0;
            byte_ctr  <= '0;
            len_ctr   <= '0;
            last_flag <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            word_reg[{byte_ctr, 3'b000} +: 8] <= byte_data;
            byte_ctr <= byte_ctr + 1'b1;
            len_ctr  <= len_ctr + 1'b1;
            if (byte_ctr == LAST_IDX) last_flag <= end_msg;
          end
        end
        ST_COMP_WAIT: begin
          if (core_ready) begin
            word_reg  <= '0;
            last_flag <= 1'b0;
          end
        end
        // Unfilled byte lanes were zeroed when the previous word retired.
        ST_PAD: word_reg[WORD_W-1 -: 8] <= len_ctr;
        ST_FIN_C_WAIT: begin
          if (core_ready) word_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign byte_ready     = ready_c & ~reset;
  assign core_initalize = init_c & ~reset;
  assign core_compress  = comp_c & ~reset;
  assign core_finalize  = fin_c & ~reset;
  assign done           = done_c & ~reset;
  assign busy           = (state != ST_IDLE) & ~reset;
  assign core_mi        = (mi_sel & ~reset) ? word_reg : '0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_siphash_msg_padder.sv
// Randomized bench for siphash_msg_padder with a reactive core model and a
// word-level reference model of the padded message.
module tb_siphash_msg_padder;
  import siphash_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        end_msg;
  logic        core_ready;
  logic        core_initalize;
  logic        core_compress;
  logic        core_finalize;
  logic [63:0] core_mi;
  logic        busy;
  logic        done;
  state_e      state_dbg;

  siphash_msg_padder dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .byte_data      (byte_data),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .end_msg        (end_msg),
    .core_ready     (core_ready),
    .core_initalize (core_initalize),
    .core_compress  (core_compress),
    .core_finalize  (core_finalize),
    .core_mi        (core_mi),
    .busy           (busy),
    .done           (done),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_init, n_comp, n_fin, n_done;
  logic [63:0] mi_hold;
  bit          hold_act = 1'b0;
  bit          cmd_seen = 1'b0;
  bit          stall_mode = 1'b0;
  int          stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Core model: ready drops the cycle after any command, returns after a delay.
  initial core_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      core_ready = 1'b1;
      stall_cnt  = 0;
    end else if (cmd_seen) begin
      core_ready = 1'b0;
      stall_cnt  = stall_mode ? 4 : int'($urandom_range(0, 3));
    end else if (!core_ready) begin
      if (stall_cnt == 0) core_ready = 1'b1;
      else                stall_cnt--;
    end
  end

  // Monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cmd_seen = core_initalize | core_compress | core_finalize;
    if (reset) begin
      hold_act = 1'b0;
    end else begin
      if (cmd_seen) begin
        check("cmd_onehot", 64'(int'(core_initalize) + int'(core_compress) + int'(core_finalize)), 64'd1);
        check("cmd_when_ready", 64'(core_ready), 64'd1);
      end
      if (core_initalize) n_init++;
      if (core_compress) begin
        n_comp++;
        if (exp_q.size() == 0) check("comp_unexpected", 64'd1, 64'd0);
        else                   check("comp_word", core_mi, exp_q.pop_front());
        mi_hold  = core_mi;
        hold_act = 1'b1;
      end else if (hold_act) begin
        if (state_dbg == ST_COMP_WAIT || state_dbg == ST_FIN_C_WAIT) begin
          check("wait_mi_stable", core_mi, mi_hold);
          check("wait_byte_ready", 64'(byte_ready), 64'd0);
        end else begin
          hold_act = 1'b0;
        end
      end
      if (core_finalize) n_fin++;
      if (done) begin
        n_done++;
        check("done_after_fin", 64'(n_fin), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input logic [7:0] d, input bit with_end);
    bit acc;
    int wait_n;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = d;
    end_msg    = with_end;
    start      = ($urandom_range(0, 7) == 0);
    acc = 1'b0;
    wait_n = 0;
    while (!acc && wait_n < 200) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #1;
      wait_n++;
    end
    if (!acc) check("byte_timeout", 64'd0, 64'd1);
    byte_valid = 1'b0;
    end_msg    = 1'b0;
    start      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_msg(input int len, input bit end_on_last, input bit use_ramp);
    logic [7:0]  msg[$];
    logic [63:0] w;
    logic [7:0]  len_b;
    int          wait_n;
    bit          acc;
    for (int i = 0; i < len; i++) msg.push_back(use_ramp ? 8'(i) : 8'($urandom));
    // Reference: full words little-endian, then tail bytes with (len mod 256) on top.
    for (int k = 0; k < len / 8; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) w |= {56'b0, msg[8*k+j]} << (8*j);
      exp_q.push_back(w);
    end
    w = '0;
    for (int j = 0; j < len % 8; j++) w |= {56'b0, msg[(len/8)*8+j]} << (8*j);
    len_b = 8'(len % 256);
    w[63:56] = len_b;
    exp_q.push_back(w);
    n_init = 0; n_comp = 0; n_fin = 0; n_done = 0;
    pulse_start();
    for (int i = 0; i < len; i++) drive_byte(msg[i], end_on_last && (i == len - 1));
    if (!(end_on_last && len > 0)) begin
      end_msg = 1'b1;
      acc = 1'b0;
      wait_n = 0;
      while (!acc && wait_n < 200) begin
        @(negedge clk);
        acc = byte_ready;
        @(posedge clk); #1;
        wait_n++;
      end
      if (!acc) check("end_timeout", 64'd0, 64'd1);
      end_msg = 1'b0;
    end
    wait_n = 0;
    while (n_done == 0 && wait_n < 2000) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("done_seen", 64'(n_done != 0), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("done_once", 64'(n_done), 64'd1);
    check("n_init", 64'(n_init), 64'd1);
    check("n_comp", 64'(n_comp), 64'(len / 8 + 1));
    check("n_fin", 64'(n_fin), 64'd1);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    int wait_n;
    exp_q.delete();
    exp_q.push_back(64'h0706050403020100);
    n_comp = 0;
    stall_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) drive_byte(8'(i), 1'b0);
    wait_n = 0;
    while (state_dbg != ST_COMP_WAIT && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("reach_comp_wait", 64'(state_dbg == ST_COMP_WAIT), 64'd1);
    check("comp_before_reset", 64'(n_comp), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    stall_mode = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_mid_core_mi", core_mi, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; end_msg = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    check("rst_init", 64'(core_initalize), 64'd0);
    check("rst_comp", 64'(core_compress), 64'd0);
    check("rst_fin", 64'(core_finalize), 64'd0);
    check("rst_core_mi", core_mi, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_byte_ready", 64'(byte_ready), 64'd0);
    check("post_rst_core_mi", core_mi, 64'd0);
    @(posedge clk); #1;

    run_msg(0, 1'b0, 1'b1);
    run_msg(8, 1'b0, 1'b1);
    run_msg(15, 1'b1, 1'b1);
    stall_mode = 1'b1;
    run_msg(20, 1'b0, 1'b0);
    stall_mode = 1'b0;
    run_msg(256, 1'b0, 1'b1);
    run_msg(7, 1'b1, 1'b0);
    reset_mid();
    run_msg(8, 1'b1, 1'b1);
    for (int r = 0; r < 8; r++) begin
      int l;
      l = int'($urandom_range(0, 40));
      stall_mode = ($urandom_range(0, 3) == 0);
      run_msg(l, (l > 0) && ($urandom_range(0, 1) == 1), 1'b0);
    end
    stall_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/siphash_msg_padder.md
SIPHASH_MSG_PADDER -- requirements
Module: siphash_msg_padder

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  one-cycle strobe that begins a new message; honoured only in IDLE.
REQ-004 byte_data  in  8  message byte.
REQ-005 byte_valid  in  1  byte_data is valid.
REQ-006 byte_ready  out  1  padder accepts a byte; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-007 end_msg  in  1  message-end strobe; honoured only in COLLECT.
REQ-008 core_ready  in  1  ready output of the SipHash core.
REQ-009 core_initalize  out  1  one-cycle command to the core: load the key state.
REQ-010 core_compress  out  1  one-cycle command to the core: absorb core_mi.
REQ-011 core_finalize  out  1  one-cycle command to the core: run finalization.
REQ-012 core_mi  out  64  message word presented to the core.
REQ-013 busy  out  1  1 in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse when the core completes finalization.

Function
REQ-015 FSM states: IDLE, INIT, COLLECT, COMP_ISSUE, COMP_WAIT, PAD, FIN_C_ISSUE, FIN_C_WAIT, FIN_ISSUE, FIN_WAIT.
REQ-016 IDLE: on start, clear word_reg (64 b), byte_ctr (3 b), len_ctr (8 b) and last_flag, then go to INIT.
REQ-017 INIT: wait for core_ready=1, assert core_initalize for exactly one cycle, then go to COLLECT.
REQ-018 COLLECT: byte_ready=1; core commands are held at 0 in this state.
REQ-019 Byte packing:
  - an accepted byte is written to word_reg[8*byte_ctr+7 : 8*byte_ctr] (little-endian);
  - byte_ctr and len_ctr each increment by 1;
  - len_ctr wraps modulo 256.
REQ-020 An accepted byte with byte_ctr=7 sets byte_ctr to 0 and moves the FSM to COMP_ISSUE; last_flag is set if end_msg is 1 in the same cycle.
REQ-021 end_msg in COLLECT with no word completed moves the FSM to PAD.
  - A byte accepted in the same cycle is part of the message.
  - If that byte completes a word, REQ-020 applies instead.
REQ-022 COMP_ISSUE: core_mi=word_reg; on core_ready=1, assert core_compress for one cycle and go to COMP_WAIT.
REQ-023 COMP_WAIT: wait for core_ready=1, then clear word_reg.
  - last_flag=1: go to PAD.
  - last_flag=0: go to COLLECT.
REQ-024 PAD: word_reg[63:56] <= len_ctr; bytes at positions >= byte_ctr are already zero; go to FIN_C_ISSUE.
REQ-025 FIN_C_ISSUE / FIN_C_WAIT: same as COMP_ISSUE / COMP_WAIT, except the exit is to FIN_ISSUE.
REQ-026 FIN_ISSUE: on core_ready=1, assert core_finalize for one cycle and go to FIN_WAIT.
REQ-027 FIN_WAIT: on core_ready=1, pulse done for one cycle and go to IDLE.
REQ-028 Every command is issued only when core_ready=1, and at most one command is active per cycle.
  - The core drops ready on the cycle after a command, so a WAIT state never sees a stale high.
REQ-029 The core_mi value is held stable from the issue cycle until the corresponding WAIT state exits.
REQ-030 start outside IDLE and end_msg outside COLLECT are ignored.
REQ-031 A message of length L produces floor(L/8) compress commands, then one padded compress, then one finalize.

Reset
REQ-032 reset forces state=IDLE and all counters/flags to 0 on the next clock edge, including mid-operation.
REQ-033 Output values while reset is active and immediately after it: byte_ready=0, core_initalize=0, core_compress=0, core_finalize=0, core_mi=0, busy=0, done=0.

Structure
REQ-034 A shared package siphash_pkg holds the FSM state encodings and the SipHash word-width constants (64-bit word, 8 bytes per word).
REQ-035 The design is a single module with no sub-modules; the command handshake is a 2-state pattern that is reused inline.

Verification
REQ-036 Empty message: start, then end_msg -> no core_compress before the padded word; core_mi=0x0000000000000000 is compressed, then finalize, then done.
REQ-037 8 bytes 00..07 ->
  - compress core_mi=0x0706050403020100;
  - then compress core_mi=0x0800000000000000;
  - then finalize, then done.
REQ-038 15 bytes 00..0e with end_msg on the last byte, key 000102..0f, core SipHash-2-4 ->
  - compress words 0x0706050403020100 and 0x0f0e0d0c0b0a0908;
  - 64-bit hash 0xa129ca6149be45e5.
REQ-039 Core ready held low for 5 cycles after a command -> the padder stays in the WAIT state with core_mi stable, and byte_ready stays 0.
REQ-040 256-byte message -> 32 compressed full words, then final core_mi=0x0000000000000000 (length byte wraps to 0x00).
REQ-041 Reset asserted during COMP_WAIT -> next cycle busy=0 and byte_ready=0; a subsequent start runs cleanly.
